// File: rtl/fetch_issue_ctrl.sv
// Instruction queue between fetch_unit and the dual-issue backend, with intra-pair RAW/branch scheduling.
// Latency: fetch -> issue slot 0 is one cycle minimum; redirect, stall and branch outputs are combinational.
// Backpressure: fetch_stall asserts above DEPTH-2 occupancy; issue valids never wait on issue_ready.
module fetch_issue_ctrl #(
    parameter int         DEPTH     = 8,
    parameter logic [3:0] OP_BRANCH = 4'hC,
    parameter logic [3:0] OP_STORE  = 4'hB
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetch_valid,
    input  logic                     fetch_single,
    input  logic [15:0]              instr1,
    input  logic [15:0]              instr2,
    output logic                     fetch_stall,
    output logic                     is_branch_taken,
    output logic [15:0]              branch_target,
    input  logic                     redirect_valid,
    input  logic [15:0]              redirect_target,
    input  logic                     issue_ready,
    output logic                     issue_valid0,
    output logic [15:0]              issue_instr0,
    output logic                     issue_valid1,
    output logic [15:0]              issue_instr1,
    output logic [$clog2(DEPTH):0]   queue_count,
    output logic [15:0]              dual_issue_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [15:0]   ins_h;
    logic [15:0]   ins_n;
    logic          has1;
    logic          has2;
    logic          hazard;
    logic          enq_en;
    logic [1:0]    enq_num;
    logic [1:0]    deq_num;

    function automatic logic writes_rd(input logic [15:0] ins);
        return (ins[15:12] != OP_BRANCH) && (ins[15:12] != OP_STORE);
    endfunction

    assign ins_h  = mem[head];
    assign ins_n  = mem[head + PW'(1)];
    assign has1   = (count != '0);
    assign has2   = (count >= CW'(2));
    assign hazard = writes_rd(ins_h) &&
                    ((ins_n[8:6] == ins_h[11:9]) || (ins_n[5:3] == ins_h[11:9]));

    // Stall looks only at registered occupancy so an accepted pair always fits.
    assign fetch_stall     = (count > CW'(DEPTH - 2));
    assign is_branch_taken = redirect_valid;
    assign branch_target   = redirect_valid ? redirect_target : 16'h0000;

    assign issue_valid0 = has1 && !redirect_valid;
    assign issue_valid1 = has2 && !redirect_valid && (ins_h[15:12] != OP_BRANCH) && !hazard;
    assign issue_instr0 = has1 ? ins_h : 16'h0000;
    assign issue_instr1 = has2 ? ins_n : 16'h0000;
    assign queue_count  = count;

    assign enq_en  = fetch_valid && !fetch_stall && !redirect_valid;
    assign enq_num = enq_en ? (fetch_single ? 2'd1 : 2'd2) : 2'd0;
    assign deq_num = issue_ready ? ({1'b0, issue_valid0} + {1'b0, issue_valid1}) : 2'd0;

    always_ff @(posedge clk) begin
        if (enq_en) begin
            mem[tail] <= instr1;
            if (!fetch_single) begin
                mem[tail + PW'(1)] <= instr2;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            dual_issue_cnt <= 16'h0000;
        end else begin
            if (redirect_valid) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                head  <= head + PW'(deq_num);
                tail  <= tail + PW'(enq_num);
                count <= count + CW'(enq_num) - CW'(deq_num);
            end
            if (issue_ready && issue_valid0 && issue_valid1 && (dual_issue_cnt != 16'hFFFF)) begin
                dual_issue_cnt <= dual_issue_cnt + 16'h0001;
            end
        end
    end
endmodule

// File: doc/fetch_issue_ctrl.md
Name: fetch_issue_ctrl

Overview:
Controller between fetch_unit and the dual-issue backend. It buffers fetched 16-bit instruction pairs in a circular queue and generates fetch_unit's stall, is_branch_taken and branch_target. It schedules dual or single issue per cycle by checking intra-pair RAW hazards and branches. It flushes all wrong-path state on a branch redirect from execute.

Parameters:
DEPTH, 8, queue entries; power of two, >= 4
OP_BRANCH, 4'hC, opcode of branch instructions (no register write)
OP_STORE, 4'hB, opcode of store instructions (no register write)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
fetch_valid  input  1  fetch_unit outputs carry valid instructions this cycle
fetch_single  input  1  only instr1 is valid (fetch in single-instruction mode)
instr1  input  16  older fetched instruction
instr2  input  16  younger fetched instruction
fetch_stall  output  1  to fetch_unit stall
is_branch_taken  output  1  to fetch_unit redirect
branch_target  output  16  to fetch_unit redirect PC
redirect_valid  input  1  taken branch resolved in execute
redirect_target  input  16  resolved target PC
issue_ready  input  1  backend accepts this cycle's issue slots
issue_valid0  output  1  slot 0 valid
issue_instr0  output  16  slot 0 instruction (queue head)
issue_valid1  output  1  slot 1 valid
issue_instr1  output  16  slot 1 instruction (head+1)
queue_count  output  $clog2(DEPTH)+1  current occupancy
dual_issue_cnt  output  16  count of dual-issue handshakes, saturating

Behaviour:
- Encoding: [15:12] op, [11:9] rd, [8:6] rs1, [5:3] rs2. An instruction writes rd when op is neither OP_BRANCH nor OP_STORE.
- Reset (reset=0, async): head/tail pointers 0, count 0, dual_issue_cnt 0. All outputs 0. fetch_stall=0 during and after reset.
- fetch_stall = (count > DEPTH-2), combinational from registered count. It ignores same-cycle dequeue, so any accepted enqueue of up to 2 always fits.
- Enqueue when fetch_valid && !fetch_stall && !redirect_valid:
  - instr1 written at tail;
  - instr2 at tail+1 unless fetch_single;
  - tail advances by 1 or 2, wrapping mod DEPTH.
- issue_valid0 = (count>=1) && !redirect_valid. issue_instr0 = queue[head].
- issue_valid1 = (count>=2) && !redirect_valid && head op != OP_BRANCH && !hazard, where hazard = head writes && (rs1(head+1)==rd(head) || rs2(head+1)==rd(head)).
- Valids never depend on issue_ready. Dequeue count = issue_ready ? issue_valid0+issue_valid1 : 0. head advances accordingly and wraps.
- Same-cycle enqueue and dequeue: count_next = count + enq - deq. Enqueue may write the slot being dequeued only after wrap; no bypass from fetch to issue (minimum latency fetch->issue = 1 cycle).
- Redirect (redirect_valid=1):
  - is_branch_taken=redirect_valid and branch_target=redirect_target, combinational pass-through;
  - same cycle: no issue, no enqueue (fetch data that cycle is wrong-path);
  - next edge: head=tail=0, count=0. Fetch data the following cycle is from the target and is enqueued normally.
  - Redirect has priority over every other event. Otherwise is_branch_taken=0 and branch_target=0.
- dual_issue_cnt increments on each edge where issue_ready && issue_valid0 && issue_valid1. It holds at 16'hFFFF.
- Mid-operation reset clears the queue immediately. No instruction issues until refill.

Test Plan:
- Independent pair: reset release, fetch_valid=1 instr1=16'h1298 instr2=16'h1C98, issue_ready=1 -> next cycle issue_valid0/1=1 with 1298/1C98; dual_issue_cnt=1; queue_count returns to 0.
- RAW hazard: enqueue 16'h1298 then 16'h1868 (reads r1) -> cycle 1 only slot0 (1298) valid; next cycle 1868 issues in slot0; dual_issue_cnt unchanged.
- Branch at head: enqueue 16'hC000, 16'h1C98 -> C000 issues alone, 1C98 issues next cycle in slot0.
- Backpressure/full: issue_ready=0, DEPTH=8, four dual fetches -> fetch_stall=1 once queue_count=7 or 8; further fetch_valid ignored. Release issue_ready -> in-order drain, pointer wrap verified by continuing fetches to 20 instructions with no loss.
- Redirect: queue_count=5, redirect_valid=1 target=16'h0040 while fetch_valid=1 -> is_branch_taken=1 and branch_target=0040 same cycle; both issue_valid=0; queue_count=0 next cycle; next fetched pair is enqueued.
- Async reset mid-stream: drop reset between edges with queue_count=4 -> outputs 0 immediately; after release, first enqueued instruction appears at issue_instr0.
